// File: rtl/eye_window_finder_pkg.sv
// Shared types and helpers for the eye window finder
// and the histogram blocks around it.
package eye_window_pkg;

  localparam int DELAY_TAPS_DEF  = 32;
  localparam int COUNT_WIDTH_DEF = 24;
  localparam int MAX_CW          = 32;
  localparam int MAX_HIST_W      = 32 * MAX_CW;

  function automatic int tap_bits_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int TAP_BITS = tap_bits_f(DELAY_TAPS_DEF);

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  // Count slice t of a packed histogram whose counts are cw bits wide
  function automatic logic [MAX_CW-1:0] get_count(
    input logic [MAX_HIST_W-1:0] hist,
    input int unsigned           t,
    input int unsigned           cw
  );
    logic [MAX_HIST_W-1:0] sh;
    logic [MAX_CW-1:0]     mask;
    sh   = hist >> (t * cw);
    mask = (cw >= MAX_CW) ? '1
         : ((MAX_CW'(1) << cw) - MAX_CW'(1));
    return sh[MAX_CW-1:0] & mask;
  endfunction

endpackage

// File: rtl/eye_window_finder_if.sv
// Histogram-in / eye-result-out bundle
// between the error counter and the eye finder.
interface eye_window_finder_if
  import eye_window_pkg::*;
#(
  parameter int DELAY_TAPS  = DELAY_TAPS_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
);

  localparam int TBITS = tap_bits_f(DELAY_TAPS);

  logic                              I_STB;
  logic [DELAY_TAPS*COUNT_WIDTH-1:0] I_DAT;
  logic                              BUSY;
  logic                              O_STB;
  logic                              O_VALID;
  logic [TBITS-1:0]                  O_START;
  logic [TBITS:0]                    O_WIDTH;
  logic [TBITS-1:0]                  O_CENTER;

  modport master (
    output I_STB, I_DAT,
    input  BUSY, O_STB, O_VALID,
    input  O_START, O_WIDTH, O_CENTER
  );

  modport slave (
    input  I_STB, I_DAT,
    output BUSY, O_STB, O_VALID,
    output O_START, O_WIDTH, O_CENTER
  );

endinterface

// File: rtl/eye_window_finder.sv
// Scans a captured per-tap error histogram and reports
// the widest contiguous run of good taps and its centre.
module eye_window_finder
  import eye_window_pkg::*;
#(
  parameter int          COUNT_WIDTH   = COUNT_WIDTH_DEF,
  parameter int          DELAY_TAPS    = DELAY_TAPS_DEF,
  parameter int unsigned ERR_THRESHOLD = 0
) (
  input logic                CLK,
  input logic                RSTN,
  eye_window_finder_if.slave bus
);

  localparam int TBITS = tap_bits_f(DELAY_TAPS);
  localparam int HW    = DELAY_TAPS * COUNT_WIDTH;

  localparam logic [TBITS-1:0] LAST  = TBITS'(DELAY_TAPS - 1);
  localparam logic [TBITS-1:0] ONE_T = TBITS'(1);
  localparam logic [TBITS:0]   ONE_L = (TBITS + 1)'(1);

  localparam logic [COUNT_WIDTH-1:0] THR =
    COUNT_WIDTH'(ERR_THRESHOLD);

  state_e state_q, state_d;

  logic [HW-1:0] snap_q, snap_d;

  logic [TBITS-1:0] idx_q, idx_d;
  logic [TBITS-1:0] cur_start_q, cur_start_d;
  logic [TBITS:0]   cur_len_q, cur_len_d;
  logic [TBITS-1:0] best_start_q, best_start_d;
  logic [TBITS:0]   best_len_q, best_len_d;

  logic             busy_q, busy_d;
  logic             ostb_q, ostb_d;
  logic             valid_q, valid_d;
  logic [TBITS-1:0] start_q, start_d;
  logic [TBITS:0]   width_q, width_d;
  logic [TBITS-1:0] center_q, center_d;

  logic [COUNT_WIDTH-1:0] cnt;
  logic                   good;
  logic [TBITS:0]         run_len;
  logic [TBITS-1:0]       run_start;
  logic [TBITS:0]         fin_len;
  logic [TBITS-1:0]       fin_start;
  logic [TBITS:0]         ctr_sum;
  logic                   fin_valid;

  // Classify the current tap and fold it into the run tracker
  always_comb begin
    cnt = COUNT_WIDTH'(get_count(
      MAX_HIST_W'(snap_q), 32'(idx_q), COUNT_WIDTH));
    good = (cnt <= THR);
    run_len = good ? (cur_len_q + ONE_L) : '0;
    run_start = (good && (cur_len_q == '0))
              ? idx_q : cur_start_q;
    if (run_len > best_len_q) begin
      fin_len   = run_len;
      fin_start = run_start;
    end else begin
      fin_len   = best_len_q;
      fin_start = best_start_q;
    end
    fin_valid = (fin_len != '0);
    ctr_sum = {1'b0, fin_start}
            + ((fin_len - ONE_L) >> 1);
  end

  // Next-state and result logic for the IDLE/SCAN sequencer
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    idx_d        = idx_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    busy_d       = busy_q;
    ostb_d       = 1'b0;
    valid_d      = valid_q;
    start_d      = start_q;
    width_d      = width_q;
    center_d     = center_q;
    unique case (state_q)
      IDLE: begin
        if (bus.I_STB) begin
          snap_d       = bus.I_DAT;
          idx_d        = '0;
          cur_start_d  = '0;
          cur_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          busy_d       = 1'b1;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        idx_d        = idx_q + ONE_T;
        cur_len_d    = run_len;
        cur_start_d  = run_start;
        best_len_d   = fin_len;
        best_start_d = fin_start;
        if (idx_q == LAST) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          ostb_d   = 1'b1;
          valid_d  = fin_valid;
          start_d  = fin_valid ? fin_start : '0;
          width_d  = fin_len;
          center_d = fin_valid
                   ? ctr_sum[TBITS-1:0] : '0;
        end
      end
    endcase
  end

  // Control, tracker and result registers
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      busy_q       <= 1'b0;
      ostb_q       <= 1'b0;
      valid_q      <= 1'b0;
      start_q      <= '0;
      width_q      <= '0;
      center_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      busy_q       <= busy_d;
      ostb_q       <= ostb_d;
      valid_q      <= valid_d;
      start_q      <= start_d;
      width_q      <= width_d;
      center_q     <= center_d;
    end
  end

  // Histogram snapshot; only ever read during SCAN
  always_ff @(posedge CLK) begin
    snap_q <= snap_d;
  end

  assign bus.BUSY     = busy_q;
  assign bus.O_STB    = ostb_q;
  assign bus.O_VALID  = valid_q;
  assign bus.O_START  = start_q;
  assign bus.O_WIDTH  = width_q;
  assign bus.O_CENTER = center_q;

endmodule

// File: tb/tb_eye_window_finder.sv
// Bench for eye_window_finder: fixed table, corner
// sequences and random histograms against a run model.
module tb_eye_window_finder;

  localparam int NT = 32;
  localparam int CW = 24;
  localparam int HW = NT * CW;

  typedef logic [HW-1:0] hist_t;

  typedef struct {
    int v;
    int s;
    int w;
    int c;
  } res_t;

  typedef struct {
    string nm;
    hist_t hist;
    res_t  e0;
    res_t  e5;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  eye_window_finder_if #(.DELAY_TAPS(NT), .COUNT_WIDTH(CW)) bus0();
  eye_window_finder_if #(.DELAY_TAPS(NT), .COUNT_WIDTH(CW)) bus5();

  eye_window_finder #(
    .COUNT_WIDTH(CW), .DELAY_TAPS(NT), .ERR_THRESHOLD(0)
  ) dut0 (.CLK(clk), .RSTN(rstn), .bus(bus0));

  eye_window_finder #(
    .COUNT_WIDTH(CW), .DELAY_TAPS(NT), .ERR_THRESHOLD(5)
  ) dut5 (.CLK(clk), .RSTN(rstn), .bus(bus5));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t mk(int v, int s, int w, int c);
    res_t r;
    r.v = v; r.s = s; r.w = w; r.c = c;
    return r;
  endfunction

  function automatic hist_t fill(int lo, int hi,
                                 logic [CW-1:0] in_v,
                                 logic [CW-1:0] out_v);
    hist_t h;
    for (int t = 0; t < NT; t++)
      h[t*CW +: CW] = (t >= lo && t <= hi) ? in_v : out_v;
    return h;
  endfunction

  function automatic hist_t rand_bits();
    hist_t h;
    for (int i = 0; i < HW / 32; i++)
      h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  // Enumerate every maximal good run; keep the first longest
  function automatic res_t ref_model(hist_t h, int thr);
    res_t r;
    int t, s, bs, bw;
    bs = 0; bw = 0; t = 0;
    while (t < NT) begin
      if (int'(h[t*CW +: CW]) <= thr) begin
        s = t;
        while (t < NT && int'(h[t*CW +: CW]) <= thr) t++;
        if (t - s > bw) begin
          bw = t - s;
          bs = s;
        end
      end else begin
        t++;
      end
    end
    r.v = (bw > 0) ? 1 : 0;
    r.w = bw;
    r.s = (bw > 0) ? bs : 0;
    r.c = (bw > 0) ? bs + (bw - 1) / 2 : 0;
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(logic stb, hist_t h);
    bus0.I_STB = stb;
    bus0.I_DAT = h;
    bus5.I_STB = stb;
    bus5.I_DAT = h;
  endtask

  task automatic cmp_res(string nm, res_t e0, res_t e5);
    chk({nm, ".valid0"},  int'(bus0.O_VALID),  e0.v);
    chk({nm, ".start0"},  int'(bus0.O_START),  e0.s);
    chk({nm, ".width0"},  int'(bus0.O_WIDTH),  e0.w);
    chk({nm, ".center0"}, int'(bus0.O_CENTER), e0.c);
    chk({nm, ".valid5"},  int'(bus5.O_VALID),  e5.v);
    chk({nm, ".start5"},  int'(bus5.O_START),  e5.s);
    chk({nm, ".width5"},  int'(bus5.O_WIDTH),  e5.w);
    chk({nm, ".center5"}, int'(bus5.O_CENTER), e5.c);
  endtask

  task automatic chk_zero(string nm);
    res_t z;
    z = mk(0, 0, 0, 0);
    chk({nm, ".busy0"}, int'(bus0.BUSY), 0);
    chk({nm, ".stb0"},  int'(bus0.O_STB), 0);
    chk({nm, ".busy5"}, int'(bus5.BUSY), 0);
    chk({nm, ".stb5"},  int'(bus5.O_STB), 0);
    cmp_res(nm, z, z);
  endtask

  // Call just before a rising edge; returns the accepting edge
  task automatic start_hist(hist_t h, output int k);
    drive(1'b1, h);
    @(posedge clk);
    #1;
    k = cyc;
    drive(1'b0, rand_bits());
  endtask

  // Bounded wait for O_STB; lat in edges after the accept edge
  task automatic wait_ostb(int k, output int lat, output int nb);
    lat = -1;
    nb  = 0;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      @(negedge clk);
      if (bus0.O_STB) lat = cyc - k;
      else if (bus0.BUSY) nb++;
    end
  endtask

  task automatic run_vec(string nm, hist_t h, res_t e0, res_t e5);
    int k, lat, nb;
    @(negedge clk);
    start_hist(h, k);
    wait_ostb(k, lat, nb);
    chk({nm, ".lat"}, lat, NT);
    chk({nm, ".busycyc"}, nb, NT);
    chk({nm, ".busy_at_stb"}, int'(bus0.BUSY), 0);
    chk({nm, ".stb5"}, int'(bus5.O_STB), 1);
    cmp_res(nm, e0, e5);
    @(negedge clk);
    chk({nm, ".pulse"}, int'(bus0.O_STB), 0);
    cmp_res({nm, ".hold"}, e0, e5);
  endtask

  function automatic hist_t rand_hist();
    hist_t h;
    int t, len, kind;
    logic [CW-1:0] v;
    t = 0;
    while (t < NT) begin
      len  = $urandom_range(1, 9);
      kind = $urandom_range(0, 3);
      for (int j = 0; j < len && t < NT; j++) begin
        case (kind)
          0:       v = '0;
          1:       v = CW'($urandom_range(1, 5));
          2:       v = CW'($urandom_range(6, 9));
          default: v = CW'($urandom_range(10, 24'hFFFFFF));
        endcase
        h[t*CW +: CW] = v;
        t++;
      end
    end
    return h;
  endfunction

  vec_t tbl[8];

  initial begin
    int k, k2, lat, lat2, nb, n_stb;
    hist_t h;

    tbl[0] = '{"allgood", fill(0, 31, 0, 0),
               mk(1, 0, 32, 15), mk(1, 0, 32, 15)};
    tbl[1] = '{"win10", fill(10, 19, 0, 1000),
               mk(1, 10, 10, 14), mk(1, 10, 10, 14)};
    tbl[2] = '{"win28", fill(28, 31, 0, 1000),
               mk(1, 28, 4, 29), mk(1, 28, 4, 29)};
    h = fill(2, 5, 0, 1000);
    for (int t = 20; t <= 23; t++) h[t*CW +: CW] = '0;
    tbl[3] = '{"tie", h, mk(1, 2, 4, 3), mk(1, 2, 4, 3)};
    tbl[4] = '{"allbad", fill(0, 31, 24'hFFFFFF, 24'hFFFFFF),
               mk(0, 0, 0, 0), mk(0, 0, 0, 0)};
    h = fill(0, 7, 5, 0);
    h[8*CW +: CW] = 24'd6;
    tbl[5] = '{"thr", h, mk(1, 9, 23, 20), mk(1, 9, 23, 20)};
    tbl[6] = '{"thr56", fill(0, 9, 5, 6),
               mk(0, 0, 0, 0), mk(1, 0, 10, 4)};
    tbl[7] = '{"tap0", fill(0, 2, 0, 1),
               mk(1, 0, 3, 1), mk(1, 0, 32, 15)};

    drive(1'b0, '0);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;

    foreach (tbl[i])
      run_vec(tbl[i].nm, tbl[i].hist, tbl[i].e0, tbl[i].e5);

    // Strobe mid-scan is dropped
    @(negedge clk);
    start_hist(tbl[1].hist, k);
    repeat (4) @(negedge clk);
    drive(1'b1, tbl[0].hist);
    @(posedge clk);
    #1;
    drive(1'b0, rand_bits());
    wait_ostb(k, lat, nb);
    chk("ignore.lat", lat, NT);
    cmp_res("ignore", tbl[1].e0, tbl[1].e5);

    // Strobe in the O_STB cycle is accepted
    start_hist(tbl[2].hist, k2);
    wait_ostb(k2, lat2, nb);
    chk("b2b.lat", lat2, NT);
    chk("b2b.spacing", (k2 + lat2) - (k + lat), NT + 1);
    cmp_res("b2b", tbl[2].e0, tbl[2].e5);

    // Reset mid-scan aborts without a result strobe
    @(negedge clk);
    start_hist(tbl[3].hist, k);
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    n_stb = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus0.O_STB || bus5.O_STB || bus0.BUSY) n_stb++;
    end
    chk("midrst.nostb", n_stb, 0);

    for (int i = 0; i < 30; i++) begin
      h = rand_hist();
      run_vec($sformatf("rnd%0d", i), h,
              ref_model(h, 0), ref_model(h, 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
